// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types, inverse S-box table and GF(2^8) helpers for the AES decrypt unit
package ibex_pkg;

  typedef enum logic {
    AES_DSI  = 1'b0,
    AES_DSMI = 1'b1
  } aes_dec_op_e;

  typedef enum logic [1:0] {
    AES_IDLE = 2'd0,
    AES_SBOX = 2'd1,
    AES_MIX  = 2'd2,
    AES_DONE = 2'd3
  } aes_dec_state_e;

  localparam logic [7:0] AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Rotate a word left by a whole number of bytes
  function automatic logic [31:0] aes_rol_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[7:0],  w[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol_byte.sv
// rtl/aes_inv_mixcol_byte.sv - one column of InvMixColumns driven by a single substituted byte
module aes_inv_mixcol_byte
  import ibex_pkg::*;
(
  input  aes_dec_op_e op_i,
  input  logic [7:0]  s_i,
  output logic [31:0] mixed_o
);

  logic [7:0] x2, x4, x8;
  logic [7:0] m9, mb, md, me;

  // xtime chain and the four InvMixColumns coefficients; only DSMI uses them
  always_comb begin
    x2 = aes_xtime(s_i);
    x4 = aes_xtime(x2);
    x8 = aes_xtime(x4);
    m9 = x8 ^ s_i;
    mb = x8 ^ x2 ^ s_i;
    md = x8 ^ x4 ^ s_i;
    me = x8 ^ x4 ^ x2;
    mixed_o = (op_i == AES_DSMI) ? {mb, md, m9, me} : {24'h0, s_i};
  end

endmodule

// File: rtl/aes32_dec_unit.sv
// rtl/aes32_dec_unit.sv - multi-cycle aes32dsi/aes32dsmi execution unit with valid/ready_id handshake
module aes32_dec_unit
  import ibex_pkg::*;
#(
  parameter bit DataIndTiming = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        aes_en_i,
  input  logic        aes_sel_i,
  input  aes_dec_op_e aes_op_i,
  input  logic [1:0]  bs_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        ready_id_i,
  output logic        valid_o,
  output logic [31:0] result_o
);

  aes_dec_state_e state_q;
  aes_dec_op_e    op_q;
  logic [31:0]    op_a_q;
  logic [1:0]     bs_q;
  logic [7:0]     byte_q, byte_d;
  logic [7:0]     sbox_q;
  logic [31:0]    result_q, result_d;
  logic [31:0]    mixed;
  logic           valid_q;

  // Select the source byte of rs2 at capture time
  always_comb begin
    case (bs_i)
      2'd0:    byte_d = op_b_i[7:0];
      2'd1:    byte_d = op_b_i[15:8];
      2'd2:    byte_d = op_b_i[23:16];
      default: byte_d = op_b_i[31:24];
    endcase
  end

  aes_inv_mixcol_byte u_mixcol (
    .op_i    (op_q),
    .s_i     (sbox_q),
    .mixed_o (mixed)
  );

  // Rotate the mixed column into the selected byte lane and fold into rs1
  always_comb begin
    result_d = op_a_q ^ aes_rol_bytes(mixed, bs_q);
  end

  // Control FSM and datapath registers; dropping aes_en_i returns to IDLE from any busy state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= AES_IDLE;
      op_q     <= AES_DSI;
      op_a_q   <= 32'h0;
      bs_q     <= 2'd0;
      byte_q   <= 8'h0;
      sbox_q   <= 8'h0;
      result_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        AES_IDLE: begin
          if (aes_en_i) begin
            op_a_q  <= op_a_i;
            op_q    <= aes_op_i;
            bs_q    <= bs_i;
            byte_q  <= byte_d;
            state_q <= AES_SBOX;
          end
        end
        AES_SBOX: begin
          if (!aes_en_i) begin
            state_q <= AES_IDLE;
          end else begin
            sbox_q  <= AES_INV_SBOX[byte_q];
            state_q <= AES_MIX;
          end
        end
        AES_MIX: begin
          if (!aes_en_i) begin
            state_q <= AES_IDLE;
          end else begin
            result_q <= result_d;
            valid_q  <= 1'b1;
            state_q  <= AES_DONE;
          end
        end
        default: begin
          if (!aes_en_i || ready_id_i) begin
            valid_q <= 1'b0;
            state_q <= AES_IDLE;
          end
        end
      endcase
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q & {32{aes_sel_i}};

  // Latency is operand-independent by construction; only that mode is supported
  assert property (@(posedge clk_i) disable iff (!rst_ni) DataIndTiming == 1'b1);

endmodule

// File: tb/tb_aes32_dec_unit.sv
// tb/tb_aes32_dec_unit.sv - self-checking bench for aes32_dec_unit
module tb_aes32_dec_unit;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sel = 1'b1;
  logic        ready = 1'b0;
  aes_dec_op_e op_sig = AES_DSI;
  logic [1:0]  bs = 2'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        valid;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] inv_tab [256];

  typedef struct {
    aes_dec_op_e op;
    logic [1:0]  bs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  aes32_dec_unit #(.DataIndTiming(1'b1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aes_en_i   (en),
    .aes_sel_i  (sel),
    .aes_op_i   (op_sig),
    .bs_i       (bs),
    .op_a_i     (a),
    .op_b_i     (b),
    .ready_id_i (ready),
    .valid_o    (valid),
    .result_o   (res)
  );

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h0;
    aa = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Forward S-box from field inverse + affine map, then inverted into a lookup table
  task automatic build_tab();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      logic [7:0] s;
      v = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ rol8(v, 1) ^ rol8(v, 2) ^ rol8(v, 3) ^ rol8(v, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] ref_res(input aes_dec_op_e op, input logic [1:0] bsel,
                                          input logic [31:0] ra, input logic [31:0] rb);
    logic [7:0]  x;
    logic [7:0]  s;
    logic [31:0] m;
    x = 8'((rb >> (8 * bsel)) & 32'hff);
    s = inv_tab[x];
    if (op == AES_DSMI) m = {gm(s, 8'h0b), gm(s, 8'h0d), gm(s, 8'h09), gm(s, 8'h0e)};
    else m = {24'h0, s};
    for (int i = 0; i < int'(bsel); i++) m = {m[23:0], m[31:24]};
    return ra ^ m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in IDLE, capture it, then scramble the live operands
  task automatic start_op(input aes_dec_op_e op, input logic [1:0] bsel,
                          input logic [31:0] ra, input logic [31:0] rb);
    en = 1'b1; op_sig = op; bs = bsel; a = ra; b = rb;
    step();
    op_sig = aes_dec_op_e'($urandom_range(1, 0));
    bs = 2'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_op(input string name, input aes_dec_op_e op, input logic [1:0] bsel,
                        input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] exp);
    start_op(op, bsel, ra, rb);
    check({name, "_v1"}, 32'(valid), 32'd0);
    step();
    check({name, "_v2"}, 32'(valid), 32'd0);
    step();
    check({name, "_v3"}, 32'(valid), 32'd1);
    check({name, "_res"}, res, exp);
    ready = 1'b1;
    step();
    check({name, "_acc"}, 32'(valid), 32'd0);
    ready = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    build_tab();

    tbl[0] = '{AES_DSMI, 2'd0, 32'h0,        32'h0,        32'h50A7F451};
    tbl[1] = '{AES_DSMI, 2'd1, 32'h0,        32'h0,        32'hA7F45150};
    tbl[2] = '{AES_DSI,  2'd2, 32'hFFFFFFFF, 32'h0,        32'hFFADFFFF};
    tbl[3] = '{AES_DSI,  2'd3, 32'h0,        32'h01000000, 32'h09000000};
    tbl[4] = '{AES_DSI,  2'd1, 32'h0,        32'h00006300, 32'h00000000};

    #3;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].bs, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      aes_dec_op_e op;
      logic [1:0]  bsel;
      logic [31:0] ra, rb;
      op = aes_dec_op_e'($urandom_range(1, 0));
      bsel = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rnd%0d", i), op, bsel, ra, rb, ref_res(op, bsel, ra, rb));
    end

    // Result held while ID stalls; output gated by the select
    e = ref_res(AES_DSMI, 2'd2, 32'h12345678, 32'h00AB0000);
    start_op(AES_DSMI, 2'd2, 32'h12345678, 32'h00AB0000);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_res", res, e);
      step();
    end
    sel = 1'b0;
    #1;
    check("sel_gate", res, 32'd0);
    sel = 1'b1;
    ready = 1'b1;
    step();
    check("hold_release", 32'(valid), 32'd0);
    ready = 1'b0;
    en = 1'b0;
    run_op("after_hold", AES_DSI, 2'd0, 32'hA5A5A5A5, 32'h000000FF, ref_res(AES_DSI, 2'd0, 32'hA5A5A5A5, 32'h000000FF));

    // Abort in SBOX
    start_op(AES_DSMI, 2'd0, 32'h1, 32'h2);
    en = 1'b0;
    step();
    check("abort_sbox_v1", 32'(valid), 32'd0);
    step();
    check("abort_sbox_v2", 32'(valid), 32'd0);
    run_op("after_sbox", AES_DSMI, 2'd3, 32'hCAFEBABE, 32'h7F000000, ref_res(AES_DSMI, 2'd3, 32'hCAFEBABE, 32'h7F000000));

    // Abort in MIX
    start_op(AES_DSI, 2'd1, 32'h3, 32'h4);
    step();
    en = 1'b0;
    step();
    check("abort_mix_v1", 32'(valid), 32'd0);
    step();
    check("abort_mix_v2", 32'(valid), 32'd0);
    run_op("after_mix", AES_DSI, 2'd2, 32'h0F0F0F0F, 32'h00C30000, ref_res(AES_DSI, 2'd2, 32'h0F0F0F0F, 32'h00C30000));

    // Abort together with ready in DONE
    start_op(AES_DSMI, 2'd1, 32'h5, 32'h6);
    step();
    step();
    check("abort_done_v", 32'(valid), 32'd1);
    en = 1'b0;
    ready = 1'b1;
    step();
    check("abort_done_drop", 32'(valid), 32'd0);
    ready = 1'b0;
    run_op("after_done", AES_DSMI, 2'd1, 32'h0, 32'h0000A500, ref_res(AES_DSMI, 2'd1, 32'h0, 32'h0000A500));

    // Asynchronous reset while in MIX; prior result is non-zero
    start_op(AES_DSMI, 2'd0, 32'h11111111, 32'h22);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mix_valid", 32'(valid), 32'd0);
    check("rst_mix_res", res, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_idle_valid", 32'(valid), 32'd0);
    run_op("after_rst", AES_DSMI, 2'd0, 32'h0, 32'h0, 32'h50A7F451);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
